// File: rtl/rle_decompressor.sv
// rle_decompressor: expands (symbol, run count) pairs into a byte stream.
// Input and output are valid/ready ports; consecutive runs are emitted
// back to back because the next pair is taken on the last beat of the
// current run.
module rle_decompressor #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_count,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              zero_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] sym_q, sym_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              zero_err_q, zero_err_d;

  logic last_beat;
  logic in_fire;
  logic out_fire;
  logic in_zero;

  // Output side is driven straight from registers.
  assign out_valid = (state_q == ST_EXPAND);
  assign out_data  = sym_q;
  assign busy      = (state_q == ST_EXPAND);
  assign zero_err  = zero_err_q;

  assign last_beat = (remaining_q == CNT_ONE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign in_zero   = (in_count == '0);

  // Input acceptance: always in IDLE, otherwise only when the last beat of
  // the current run leaves this cycle; held low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        in_ready = 1'b1;
      end else begin
        in_ready = last_beat && out_ready;
      end
    end
  end

  // Next-state: load a new run, count beats down, flag zero-length pairs.
  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    remaining_d = remaining_q;
    zero_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          if (in_zero) begin
            zero_err_d = 1'b1;
          end else begin
            sym_d       = in_data;
            remaining_d = in_count;
            state_d     = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        if (out_fire) begin
          if (last_beat) begin
            // Chaining a new pair here is what removes the inter-run bubble.
            if (in_fire && !in_zero) begin
              sym_d       = in_data;
              remaining_d = in_count;
            end else begin
              zero_err_d  = in_fire;
              remaining_d = '0;
              state_d     = ST_IDLE;
            end
          end else begin
            remaining_d = remaining_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any active run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sym_q       <= '0;
      remaining_q <= '0;
      zero_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      remaining_q <= remaining_d;
      zero_err_q  <= zero_err_d;
    end
  end

endmodule

// File: tb/tb_rle_decompressor.sv
// Scoreboard bench for rle_decompressor: accepted pairs push their expected
// bytes into a queue, and a negedge monitor pops and compares every output
// handshake, also checking in_ready, zero_err and stall stability.
module tb_rle_decompressor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [7:0] in_count;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       zero_err;

  rle_decompressor #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_count(in_count), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .zero_err(zero_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int zero_due = -10;
  int beats = 0;
  int zcount = 0;
  int first_beat_cyc = -1;
  int last_beat_cyc = -1;
  int acc_cyc = 0;
  int mode = 0;             // out_ready: 0 high, 1 toggling, 2 random
  logic       held_valid = 1'b0;
  logic [7:0] held_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares everything the DUT presents against the scoreboard.
  initial begin
    exp_t e;
    logic exp_ir;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("in_ready_in_reset", 32'(in_ready), 32'd0);
        held_valid = 1'b0;
      end else begin
        if (!out_valid) exp_ir = 1'b1;
        else exp_ir = (q.size() > 0) && q[0].last && out_ready;
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("zero_err", 32'(zero_err), 32'(cyc == zero_due));
        if (zero_err) zcount++;
        if (held_valid) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(held_data));
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
          end else if (out_ready) begin
            e = q.pop_front();
            check("out_data", 32'(out_data), 32'(e.d));
            beats++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
          end
        end
        held_valid = out_valid && !out_ready;
        held_data  = out_data;
      end
    end
  end

  // Offer one pair; returns at posedge+1 after it is accepted.
  task automatic send_pair(input logic [7:0] d, input logic [7:0] c);
    int n;
    in_data  = d;
    in_count = c;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        for (int i = 0; i < int'(c); i++) q.push_back('{d: d, last: (i == int'(c) - 1)});
        if (c == 8'd0) zero_due = cyc + 1;
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 5000) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    bit done;
    done = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("busy_after_drain", 32'(busy), 32'd0);
    check("out_valid_after_drain", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, b0, z0, r;
    logic [7:0] rd, rc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_zero_err", 32'(zero_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back runs, out_ready high.
    mode = 0;
    b0 = beats;
    first_beat_cyc = -1;
    send_pair(8'h41, 8'd4);
    a0 = acc_cyc;
    send_pair(8'h42, 8'd2);
    send_pair(8'h43, 8'd1);
    wait_drain(100);
    check("t1_beats", 32'(beats - b0), 32'd7);
    check("t1_latency", 32'(first_beat_cyc), 32'(a0 + 1));
    check("t1_no_bubble", 32'(last_beat_cyc - first_beat_cyc), 32'd6);

    // Same stream with toggling out_ready.
    mode = 1;
    b0 = beats;
    send_pair(8'h41, 8'd4);
    send_pair(8'h42, 8'd2);
    send_pair(8'h43, 8'd1);
    wait_drain(100);
    check("t2_beats", 32'(beats - b0), 32'd7);

    // Zero-count pairs in IDLE and on a last beat.
    mode = 0;
    b0 = beats;
    z0 = zcount;
    send_pair(8'h55, 8'd0);
    send_pair(8'h66, 8'd3);
    wait_drain(100);
    send_pair(8'h77, 8'd1);
    send_pair(8'h88, 8'd0);
    wait_drain(100);
    check("t3_beats", 32'(beats - b0), 32'd4);
    check("t3_zero_pulses", 32'(zcount - z0), 32'd2);

    // Maximum run length.
    b0 = beats;
    send_pair(8'hAA, 8'd255);
    wait_drain(400);
    check("t4_beats", 32'(beats - b0), 32'd255);

    // Reset in the middle of a run.
    b0 = beats;
    send_pair(8'h99, 8'd10);
    for (int n = 0; n < 50 && (beats - b0) < 4; n++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid_after_rst", 32'(out_valid), 32'd0);
    check("t5_out_data_after_rst", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    b0 = beats;
    send_pair(8'h11, 8'd2);
    wait_drain(100);
    check("t5_beats", 32'(beats - b0), 32'd2);

    // Random pairs with random in_valid gaps and out_ready.
    mode = 2;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 3);
      repeat (r) begin @(posedge clk); #1; end
      rd = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      send_pair(rd, rc);
    end
    wait_drain(2000);
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
